spike_packet_tx: RTL and testbench

- Output side of a neuron core: collects fire events from the neuron grid during a tick and turns each into a routed spike packet for the mesh router.
- Per fired neuron: looks up its destination (dx, dy, target axon) in a synchronous destination table, then transmits one packet over a valid/ready link.
- Tells the tick sequencer when all spikes of the current tick have left the core.

---
 rtl/snn_pkg.sv | 17 +
 rtl/spike_fifo.sv | 59 +++++
 rtl/spike_packet_tx.sv | 117 +++++++++++
 tb/tb_spike_packet_tx.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and field widths for the spike output path of a neuron core.
// The packet layout is {dx, dy, axon} with dx/dy as signed hop counts.
package snn_pkg;

    localparam int DX_W_DEF   = 9;
    localparam int DY_W_DEF   = 9;
    localparam int AXON_W_DEF = 8;
    localparam int PKT_W      = DX_W_DEF + DY_W_DEF + AXON_W_DEF;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_FETCH = 2'd1,
        TX_WAIT  = 2'd2,
        TX_SEND  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/spike_fifo.sv
// Synchronous FIFO with a combinational head output and asynchronous reset to empty.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module spike_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        push_ok  = push && (!full || pop);
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        dout     = mem_q[rd_ptr_q];
        count    = count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/spike_packet_tx.sv
// Turns buffered neuron fire events into routed spike packets, one destination
// lookup per event, and reports to the tick sequencer when the tick has drained.
module spike_packet_tx
    import snn_pkg::*;
#(
    parameter int NEURON_W   = 8,
    parameter int DX_W       = DX_W_DEF,
    parameter int DY_W       = DY_W_DEF,
    parameter int AXON_W     = AXON_W_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       spike_in,
    input  logic [NEURON_W-1:0]        neuron_num,
    input  logic                       grid_done,
    output logic                       dest_rd_en,
    output logic [NEURON_W-1:0]        dest_addr,
    input  logic [DX_W+DY_W+AXON_W-1:0] dest_data,
    output logic                       pkt_valid,
    output logic [DX_W+DY_W+AXON_W-1:0] pkt_data,
    input  logic                       pkt_ready,
    output logic                       tx_done,
    output logic                       busy,
    output logic                       overflow
);

    localparam int PW = DX_W + DY_W + AXON_W;

    tx_state_e                     state_q, state_d;
    logic [PW-1:0]                 pkt_data_q, pkt_data_d;
    logic                          done_pending_q, done_pending_d;
    logic                          overflow_q, overflow_d;

    logic                          fifo_pop;
    logic [NEURON_W-1:0]           fifo_head;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    spike_fifo #(
        .WIDTH (NEURON_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (spike_in),
        .pop     (fifo_pop),
        .din     (neuron_num),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Router link: pkt_valid rises only in SEND and stays high with pkt_data
    // frozen until the cycle pkt_ready is also high; that cycle is the transfer.
    always_comb begin
        state_d    = state_q;
        pkt_data_d = pkt_data_q;
        dest_rd_en = 1'b0;
        dest_addr  = '0;
        pkt_valid  = 1'b0;
        fifo_pop   = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    state_d = TX_FETCH;
                end
            end
            TX_FETCH: begin
                dest_rd_en = 1'b1;
                dest_addr  = fifo_head;
                fifo_pop   = 1'b1;
                state_d    = TX_WAIT;
            end
            TX_WAIT: begin
                pkt_data_d = dest_data;
                state_d    = TX_SEND;
            end
            TX_SEND: begin
                pkt_valid = 1'b1;
                // A spike landing this cycle still counts, so back-to-back
                // traffic does not detour through IDLE.
                if (pkt_ready) begin
                    state_d = ((fifo_count != '0) || spike_in) ? TX_FETCH : TX_IDLE;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        tx_done        = done_pending_q && (state_q == TX_IDLE) && fifo_empty && !spike_in;
        done_pending_d = tx_done ? 1'b0 : (done_pending_q | grid_done);
        overflow_d     = overflow_q | (spike_in && fifo_full && !fifo_pop);
        busy           = !fifo_empty || (state_q != TX_IDLE) || done_pending_q;
        pkt_data       = pkt_data_q;
        overflow       = overflow_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= TX_IDLE;
            pkt_data_q     <= '0;
            done_pending_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pkt_data_q     <= pkt_data_d;
            done_pending_q <= done_pending_d;
            overflow_q     <= overflow_d;
        end
    end

endmodule

// File: tb/tb_spike_packet_tx.sv
// Bench for spike_packet_tx: a queue-level model of buffered spikes, in-flight
// packets and tick completion, checked every cycle, plus directed timing cases.
module tb_spike_packet_tx;

    localparam int NW    = 8;
    localparam int PW    = 26;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          spike_in = 1'b0;
    logic [NW-1:0] neuron_num = '0;
    logic          grid_done = 1'b0;
    logic          pkt_ready = 1'b0;
    logic [PW-1:0] dest_data = '0;
    logic          dest_rd_en, pkt_valid, tx_done, busy, overflow;
    logic [NW-1:0] dest_addr;
    logic [PW-1:0] pkt_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [PW-1:0] tbl [256];

    // Model state
    logic [NW-1:0] mq[$];
    logic [PW-1:0] exp_q[$];
    bit            m_dp = 1'b0;
    bit            m_ovf = 1'b0;
    int            inflight = 0;
    bit            prev_stall = 1'b0;
    logic [PW-1:0] prev_data = '0;
    int            accepted = 0;
    int            sent = 0;

    // Observed event log for directed timing checks
    int            rd_cyc[$];
    int            hs_cyc[$];
    int            txd_cyc[$];
    logic [PW-1:0] hs_data[$];

    spike_packet_tx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spike_in   (spike_in),
        .neuron_num (neuron_num),
        .grid_done  (grid_done),
        .dest_rd_en (dest_rd_en),
        .dest_addr  (dest_addr),
        .dest_data  (dest_data),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .pkt_ready  (pkt_ready),
        .tx_done    (tx_done),
        .busy       (busy),
        .overflow   (overflow)
    );

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous destination table: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (dest_rd_en) dest_data <= tbl[dest_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard / compare process
    always @(negedge clk) begin
        int sz;
        bit m_busy, m_txd, pop;
        if (!reset_n) begin
            mq.delete();
            exp_q.delete();
            m_dp = 1'b0;
            m_ovf = 1'b0;
            inflight = 0;
            prev_stall = 1'b0;
        end else begin
            sz     = mq.size();
            m_busy = (sz != 0) || (inflight != 0) || m_dp;
            m_txd  = m_dp && (sz == 0) && (inflight == 0) && !spike_in;
            chk("busy", busy, m_busy);
            chk("tx_done", tx_done, m_txd);
            chk("overflow", overflow, m_ovf);
            if (prev_stall) begin
                chk("hold_valid", pkt_valid, 1);
                chk("hold_data", pkt_data, prev_data);
            end
            if (tx_done) txd_cyc.push_back(cyc);

            pop = 1'b0;
            if (dest_rd_en) begin
                rd_cyc.push_back(cyc);
                chk("fetch_legal", (sz != 0) && (inflight == 0), 1);
                if (sz != 0 && inflight == 0) begin
                    chk("dest_addr", dest_addr, mq[0]);
                    exp_q.push_back(tbl[mq[0]]);
                    void'(mq.pop_front());
                    inflight = 1;
                    pop = 1'b1;
                end
            end

            if (pkt_valid) begin
                chk("valid_has_pkt", exp_q.size() != 0, 1);
                if (pkt_ready && exp_q.size() != 0) begin
                    chk("pkt_data", pkt_data, exp_q[0]);
                    hs_cyc.push_back(cyc);
                    hs_data.push_back(pkt_data);
                    void'(exp_q.pop_front());
                    inflight = 0;
                    sent++;
                end
            end

            if (spike_in) begin
                if (sz < DEPTH || pop) begin
                    mq.push_back(neuron_num);
                    accepted++;
                end else begin
                    m_ovf = 1'b1;
                end
            end

            if (m_txd) m_dp = 1'b0;
            else if (grid_done) m_dp = 1'b1;

            prev_stall = pkt_valid && !pkt_ready;
            prev_data  = pkt_data;
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spike(input logic [NW-1:0] n);
        spike_in = 1'b1;
        neuron_num = n;
        tick();
        spike_in = 1'b0;
    endtask

    task automatic pulse_done();
        grid_done = 1'b1;
        tick();
        grid_done = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((busy || pkt_valid) && n < max) begin
            tick();
            n++;
        end
        chk("drain", busy, 0);
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!pkt_valid && n < max) begin
            tick();
            n++;
        end
        chk("wait_valid", pkt_valid, 1);
    endtask

    initial begin
        int b, rb, tb, c0, hc, acc0, sent0;
        logic [PW-1:0] held;

        for (int i = 0; i < 256; i++) tbl[i] = PW'($urandom);
        tbl[5] = {9'h001, 9'h1FF, 8'h0A};

        // Reset state
        repeat (3) tick();
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_pkt_data", pkt_data, 0);
        chk("rst_dest_rd_en", dest_rd_en, 0);
        chk("rst_dest_addr", dest_addr, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Single spike latency and payload
        pkt_ready = 1'b1;
        b = hs_cyc.size();
        rb = rd_cyc.size();
        c0 = cyc;
        spike(8'h05);
        wait_idle(200);
        chk("t1_count", hs_cyc.size() - b, 1);
        if (hs_cyc.size() > b && rd_cyc.size() > rb) begin
            chk("t1_rd_latency", rd_cyc[rb] - c0, 2);
            chk("t1_valid_latency", hs_cyc[b] - c0, 4);
            chk("t1_payload", hs_data[b], 26'h003FF0A);
        end

        // Backpressure: hold for 10 cycles, then one handshake and next fetch
        pkt_ready = 1'b0;
        b = hs_cyc.size();
        rb = rd_cyc.size();
        spike(8'h33);
        spike(8'h44);
        wait_valid(20);
        held = pkt_data;
        chk("t2_held_payload", held, tbl[8'h33]);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_valid_stable", pkt_valid, 1);
            chk("t2_data_stable", pkt_data, held);
        end
        pkt_ready = 1'b1;
        hc = cyc;
        tick();
        wait_idle(200);
        chk("t2_count", hs_cyc.size() - b, 2);
        if (hs_cyc.size() >= b + 2 && rd_cyc.size() >= rb + 2) begin
            chk("t2_hs_cycle", hs_cyc[b], hc);
            chk("t2_next_fetch", rd_cyc[rb + 1], hc + 1);
            chk("t2_second_payload", hs_data[b + 1], tbl[8'h44]);
        end

        // Burst ordering and 3-cycle throughput
        b = hs_cyc.size();
        c0 = cyc;
        for (int i = 1; i <= 4; i++) spike(NW'(i));
        wait_idle(200);
        chk("t3_count", hs_cyc.size() - b, 4);
        if (hs_cyc.size() >= b + 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("t3_order", hs_data[b + k], tbl[k + 1]);
                chk("t3_spacing", hs_cyc[b + k] - c0, 4 + 3 * k);
            end
        end

        // Overflow: 17 spikes fit (one already popped), the 18th is dropped
        pkt_ready = 1'b0;
        b = hs_cyc.size();
        for (int i = 0; i < 18; i++) begin
            if (i == 17) chk("t4_no_ovf_after_17", overflow, 0);
            spike(NW'(8'h80 + i));
        end
        chk("t4_ovf_after_18", overflow, 1);
        pkt_ready = 1'b1;
        wait_idle(500);
        chk("t4_count", hs_cyc.size() - b, 17);
        chk("t4_ovf_sticky", overflow, 1);
        if (hs_cyc.size() >= b + 17) begin
            for (int k = 0; k < 17; k++) chk("t4_order", hs_data[b + k], tbl[8'h80 + k]);
        end

        // Reset mid-SEND
        pkt_ready = 1'b0;
        spike(8'h21);
        spike(8'h22);
        wait_valid(20);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_valid_async", pkt_valid, 0);
        chk("t5_busy_async", busy, 0);
        chk("t5_ovf_async", overflow, 0);
        tick();
        reset_n = 1'b1;
        b = hs_cyc.size();
        rb = rd_cyc.size();
        pkt_ready = 1'b1;
        repeat (15) tick();
        chk("t5_no_stale_pkt", hs_cyc.size() - b, 0);
        chk("t5_no_stale_fetch", rd_cyc.size() - rb, 0);

        // Done sequencing with queued spikes
        b = hs_cyc.size();
        tb = txd_cyc.size();
        spike(8'h61);
        grid_done = 1'b1;
        spike(8'h62);
        grid_done = 1'b0;
        spike(8'h63);
        wait_idle(200);
        tick();
        chk("t6_one_pulse", txd_cyc.size() - tb, 1);
        if (txd_cyc.size() > tb && hs_cyc.size() >= b + 3)
            chk("t6_pulse_cycle", txd_cyc[tb], hs_cyc[b + 2] + 1);

        // Done with empty FIFO
        tb = txd_cyc.size();
        c0 = cyc;
        pulse_done();
        repeat (3) tick();
        chk("t7_one_pulse", txd_cyc.size() - tb, 1);
        if (txd_cyc.size() > tb) chk("t7_pulse_cycle", txd_cyc[tb], c0 + 1);

        // Repeated grid_done while pending
        pkt_ready = 1'b0;
        tb = txd_cyc.size();
        spike(8'h70);
        pulse_done();
        tick();
        pulse_done();
        pkt_ready = 1'b1;
        wait_idle(200);
        tick();
        chk("t8_one_pulse", txd_cyc.size() - tb, 1);

        // Random traffic
        acc0 = accepted;
        sent0 = sent;
        for (int i = 0; i < 3000; i++) begin
            spike_in   = ($urandom_range(0, 99) < 30);
            neuron_num = NW'($urandom_range(0, 255));
            pkt_ready  = ($urandom_range(0, 99) < 60);
            grid_done  = ($urandom_range(0, 99) < 3);
            tick();
        end
        spike_in = 1'b0;
        grid_done = 1'b0;
        pkt_ready = 1'b1;
        wait_idle(1000);
        chk("rand_all_sent", sent - sent0, accepted - acc0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
